// File: rtl/rr_arbiter3_pkg.sv
// Shared encodings for the three-way round-robin arbiter.
// State codes double as owner codes, so the state register can drive out_owner directly.
package rr_arbiter3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        OWN_C = 2'd3
    } state_t;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_A    = 2'd1;
    localparam logic [1:0] OWNER_B    = 2'd2;
    localparam logic [1:0] OWNER_C    = 2'd3;

    // Owner code -> request vector bit {C,B,A}; NONE maps to no bit.
    function automatic logic [2:0] owner_onehot(input logic [1:0] code);
        case (code)
            OWNER_A: owner_onehot = 3'b001;
            OWNER_B: owner_onehot = 3'b010;
            OWNER_C: owner_onehot = 3'b100;
            default: owner_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter3_pick.sv
// Combinational round-robin selector: first eligible requester after 'last',
// skipping 'exclude'. Returns OWNER_NONE when nobody is eligible.
module rr_pick3
    import rr_arbiter3_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic [1:0] exclude,
    output logic [1:0] next
);

    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    function automatic logic eligible(input logic [2:0] r, input logic [1:0] c,
                                      input logic [1:0] excl);
        eligible = |(r & owner_onehot(c)) && (c != excl);
    endfunction

    always_comb begin
        case (last)
            OWNER_A: begin cand0 = OWNER_B; cand1 = OWNER_C; cand2 = OWNER_A; end
            OWNER_B: begin cand0 = OWNER_C; cand1 = OWNER_A; cand2 = OWNER_B; end
            default: begin cand0 = OWNER_A; cand1 = OWNER_B; cand2 = OWNER_C; end
        endcase
    end

    // Lowest-priority candidate first so the highest-priority match wins.
    always_comb begin
        next = OWNER_NONE;
        if (eligible(req, cand2, exclude)) next = cand2;
        if (eligible(req, cand1, exclude)) next = cand1;
        if (eligible(req, cand0, exclude)) next = cand0;
    end

endmodule

// File: rtl/rr_arbiter3.sv
// Three-requester round-robin arbiter with registered one-hot grant.
// Optional forced release after MAX_HOLD held cycles: define RR_ARBITER3_TIMEOUT_EN.
module rr_arbiter3
    import rr_arbiter3_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_req_A,
    input  logic       in_req_B,
    input  logic       in_req_C,
    output logic       out_gnt_A,
    output logic       out_gnt_B,
    output logic       out_gnt_C,
    output logic       out_busy,
    output logic [1:0] out_owner,
    output logic       out_timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_param
        $error("rr_arbiter3: MAX_HOLD must fit in CNT_W bits and be at least 1");
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] last;
    logic [2:0] req;
    logic [1:0] pick_next;
    logic       owner_req;
    logic       forced;

    assign req       = {in_req_C, in_req_B, in_req_A};
    assign owner_req = |(req & owner_onehot(state));

    // The current owner is excluded; in IDLE the state code equals NONE so nothing is.
    rr_pick3 u_pick (
        .req     (req),
        .last    (last),
        .exclude (state),
        .next    (pick_next)
    );

`ifdef RR_ARBITER3_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= forced;
            if (state_nxt == IDLE || state_nxt != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign out_timeout = timeout_q;
`else
    assign out_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= OWNER_C;
        end else begin
            state <= state_nxt;
            if (state_nxt != IDLE)
                last <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        forced    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_next != OWNER_NONE)
                    state_nxt = state_t'(pick_next);
            end
            default: begin
                if (!owner_req) begin
                    // Same-edge handoff; NONE decodes to IDLE.
                    state_nxt = state_t'(pick_next);
                end
`ifdef RR_ARBITER3_TIMEOUT_EN
                else if (cnt >= HOLD_LIM && pick_next != OWNER_NONE) begin
                    state_nxt = state_t'(pick_next);
                    forced    = 1'b1;
                end
`endif
            end
        endcase
    end

    assign out_gnt_A = (state == OWN_A);
    assign out_gnt_B = (state == OWN_B);
    assign out_gnt_C = (state == OWN_C);
    assign out_busy  = (state != IDLE);
    assign out_owner = state;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Directed self-checking bench for rr_arbiter3 (default and RR_ARBITER3_TIMEOUT_EN builds).
module tb_rr_arbiter3;

    logic       clk;
    logic       rst_n;
    logic       req_a;
    logic       req_b;
    logic       req_c;
    logic       gnt_a;
    logic       gnt_b;
    logic       gnt_c;
    logic       busy;
    logic [1:0] owner;
    logic       timeout;
    logic [2:0] gnt;

    int total;
    int bad;

    assign gnt = {gnt_c, gnt_b, gnt_a};

    rr_arbiter3 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_req_A    (req_a),
        .in_req_B    (req_b),
        .in_req_C    (req_c),
        .out_gnt_A   (gnt_a),
        .out_gnt_B   (gnt_b),
        .out_gnt_C   (gnt_c),
        .out_busy    (busy),
        .out_owner   (owner),
        .out_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle at the falling edge for sampling and driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        req_c = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        req_c = 1'b1;
        step();
        step();
        total++;
        if (gnt !== 3'b000 || busy !== 1'b0 || owner !== 2'd0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: gnt=%b busy=%b owner=%0d to=%b want gnt=000 busy=0 owner=0 to=0",
                     gnt, busy, owner, timeout);
        end
        rst_n = 1'b1;
        step();
        total++;
        if (gnt !== 3'b001 || owner !== 2'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_first: gnt=%b owner=%0d busy=%b want gnt=001 owner=1 busy=1",
                     gnt, owner, busy);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_g [4];
        exp_g[0] = 3'b001;
        exp_g[1] = 3'b010;
        exp_g[2] = 3'b100;
        exp_g[3] = 3'b001;
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        req_c = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (gnt !== exp_g[i]) begin
                bad++;
                $display("FAIL rotation_%0d: gnt=%b want %b", i, gnt, exp_g[i]);
            end
            // Current owner drops; the one that dropped previously re-requests.
            case (i)
                0: req_a = 1'b0;
                1: begin req_b = 1'b0; req_a = 1'b1; end
                2: begin req_c = 1'b0; req_b = 1'b1; end
                default: ;
            endcase
            if (i < 3) step();
        end
        req_a = 1'b0;
        req_b = 1'b0;
        req_c = 1'b0;
        step();
    endtask

    task automatic test_handoff();
        do_reset();
        req_a = 1'b1;
        step();
        req_b = 1'b1;
        step();
        total++;
        if (gnt !== 3'b001 || owner !== 2'd1) begin
            bad++;
            $display("FAIL handoff_hold: gnt=%b owner=%0d want gnt=001 owner=1", gnt, owner);
        end
        req_a = 1'b0;
        step();
        total++;
        if (gnt !== 3'b010 || owner !== 2'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL handoff_to_b: gnt=%b owner=%0d busy=%b want gnt=010 owner=2 busy=1",
                     gnt, owner, busy);
        end
    endtask

    task automatic test_idle_return();
        do_reset();
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        step();
        total++;
        if (gnt !== 3'b000 || owner !== 2'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_return: gnt=%b owner=%0d busy=%b want gnt=000 owner=0 busy=0",
                     gnt, owner, busy);
        end
        req_b = 1'b1;
        step();
        total++;
        if (gnt !== 3'b010 || owner !== 2'd2) begin
            bad++;
            $display("FAIL idle_then_b: gnt=%b owner=%0d want gnt=010 owner=2", gnt, owner);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_b = 1'b1;
        req_c = 1'b1;
        step();
        total++;
        if (gnt !== 3'b010) begin
            bad++;
            $display("FAIL simul_rr_pick_b: gnt=%b want 010", gnt);
        end
        req_b = 1'b0;
        step();
        total++;
        if (gnt !== 3'b100 || owner !== 2'd3) begin
            bad++;
            $display("FAIL simul_then_c: gnt=%b owner=%0d want gnt=100 owner=3", gnt, owner);
        end
        // C owns, last=C: A requests after B so A wins on release.
        req_a = 1'b1;
        req_b = 1'b1;
        req_c = 1'b0;
        step();
        total++;
        if (gnt !== 3'b001) begin
            bad++;
            $display("FAIL simul_wrap_to_a: gnt=%b want 001", gnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_a = 1'b1;
        step();
        req_c = 1'b1;
`ifdef RR_ARBITER3_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (gnt !== 3'b001 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL timeout_hold_%0d: gnt=%b to=%b want gnt=001 to=0", k, gnt, timeout);
            end
        end
        step();
        total++;
        if (gnt !== 3'b100 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_force: gnt=%b to=%b want gnt=100 to=1", gnt, timeout);
        end
        step();
        total++;
        if (gnt !== 3'b100 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse_end: gnt=%b to=%b want gnt=100 to=0", gnt, timeout);
        end
`else
        for (int k = 1; k <= 24; k++) begin
            step();
            total++;
            if (gnt !== 3'b001 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL hold_unlimited_%0d: gnt=%b to=%b want gnt=001 to=0", k, gnt, timeout);
            end
        end
`endif
        req_a = 1'b0;
        step();
        total++;
        if (gnt !== 3'b100 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_release_to_c: gnt=%b to=%b want gnt=100 to=0", gnt, timeout);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_b = 1'b1;
        step();
        req_a = 1'b1;
        step();
        total++;
        if (gnt !== 3'b010) begin
            bad++;
            $display("FAIL async_pre_b_owns: gnt=%b want 010", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (gnt !== 3'b000 || owner !== 2'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_drop: gnt=%b owner=%0d busy=%b want gnt=000 owner=0 busy=0",
                     gnt, owner, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (gnt !== 3'b001 || owner !== 2'd1) begin
            bad++;
            $display("FAIL async_last_reset_c: gnt=%b owner=%0d want gnt=001 owner=1", gnt, owner);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        req_c = 1'b0;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_handoff();
        test_idle_return();
        test_simultaneous();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
